// File: rtl/ex_stage.sv
// ex_stage: EX pipeline stage (ALU, branch target, iterative multiply), negedge-registered EX/MEM outputs; optional EX_OVERFLOW_EN adds outOverflow
module ex_stage #(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid,
  input  logic        inFlush,
  input  logic [31:0] inAdder,
  input  logic [31:0] inRD1,
  input  logic [31:0] inRD2,
  input  logic [31:0] inSignExt,
  input  logic [4:0]  inInsA,
  input  logic [4:0]  inInsB,
  input  logic [3:0]  inAluOp,
  input  logic        inAluSrc,
  input  logic        inRegDst,
  input  logic        inBranch,
  output logic        outStall,
  output logic        outValid,
  output logic [31:0] outAluResult,
  output logic [31:0] outBranchTarget,
  output logic        outZero,
  output logic        outBranchTaken,
  output logic [31:0] outWriteData,
  output logic [4:0]  outWriteReg
`ifdef EX_OVERFLOW_EN
  ,
  output logic        outOverflow
`endif
);
  localparam int K = MUL_BITS_PER_CYCLE;
  localparam int N = 32 / K;
  localparam int CW = $clog2(N);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110,
                         OP_SLT = 4'b0111, OP_NOR = 4'b1100, OP_MUL = 4'b1000;
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nx;
  logic [CW-1:0] count;
  logic [31:0] mcand, mplier, acc, m_tgt, m_wd;
  logic [4:0] m_wr;
  logic m_br;
  logic [31:0] b, sum, diff, alu, tgt, partial, prod;
  logic is_mul, last;
`ifdef EX_OVERFLOW_EN
  logic ovf;
`endif
  // ALU, branch target, multiply step and stall/next-state decode
  always_comb begin
    b = inAluSrc ? inSignExt : inRD2;
    sum = inRD1 + b;
    diff = inRD1 - b;
    alu = inAluOp == OP_AND ? inRD1 & b :
          inAluOp == OP_OR  ? inRD1 | b :
          inAluOp == OP_ADD ? sum :
          inAluOp == OP_SUB ? diff :
          inAluOp == OP_SLT ? {31'd0, $signed(inRD1) < $signed(b)} :
          inAluOp == OP_NOR ? ~(inRD1 | b) : 32'd0;
    tgt = inAdder + {inSignExt[29:0], 2'b00};
    is_mul = inAluOp == OP_MUL;
    last = count == CW'(N - 1);
    partial = 32'd0;
    for (int j = 0; j < K; j++) partial = partial + (mplier[j] ? mcand << j : 32'd0);
    prod = acc + partial;
    outStall = ~inFlush & (state == IDLE ? inValid & is_mul : ~last);
    state_nx = inFlush ? IDLE : state == IDLE ? (inValid & is_mul ? MUL : IDLE) : (last ? IDLE : MUL);
`ifdef EX_OVERFLOW_EN
    ovf = inAluOp == OP_ADD ? (inRD1[31] == b[31]) & (sum[31] != inRD1[31]) :
          inAluOp == OP_SUB ? (inRD1[31] != b[31]) & (diff[31] != inRD1[31]) : 1'b0;
`endif
  end
  // FSM state register
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // multiplier iteration and EX/MEM output registers
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      m_tgt <= '0;
      m_wd <= '0;
      m_wr <= '0;
      m_br <= 1'b0;
      outValid <= 1'b0;
      outAluResult <= '0;
      outBranchTarget <= '0;
      outZero <= 1'b0;
      outBranchTaken <= 1'b0;
      outWriteData <= '0;
      outWriteReg <= '0;
`ifdef EX_OVERFLOW_EN
      outOverflow <= 1'b0;
`endif
    end else if (inFlush) begin
      outValid <= 1'b0;
      outBranchTaken <= 1'b0;
`ifdef EX_OVERFLOW_EN
      outOverflow <= 1'b0;
`endif
    end else if (state == MUL) begin
      acc <= prod;
      mcand <= mcand << K;
      mplier <= mplier >> K;
      count <= count + 1'b1;
      outValid <= last;
      if (last) begin
        outAluResult <= prod;
        outZero <= prod == 32'd0;
        outBranchTaken <= m_br & (prod == 32'd0);
        outBranchTarget <= m_tgt;
        outWriteData <= m_wd;
        outWriteReg <= m_wr;
`ifdef EX_OVERFLOW_EN
        outOverflow <= 1'b0;
`endif
      end
    end else if (inValid & is_mul) begin
      mcand <= inRD1;
      mplier <= b;
      acc <= '0;
      count <= '0;
      m_tgt <= tgt;
      m_wd <= inRD2;
      m_wr <= inRegDst ? inInsB : inInsA;
      m_br <= inBranch;
      outValid <= 1'b0;
    end else if (inValid) begin
      outValid <= 1'b1;
      outAluResult <= alu;
      outZero <= alu == 32'd0;
      outBranchTaken <= inBranch & (alu == 32'd0);
      outBranchTarget <= tgt;
      outWriteData <= inRD2;
      outWriteReg <= inRegDst ? inInsB : inInsA;
`ifdef EX_OVERFLOW_EN
      outOverflow <= ovf;
`endif
    end else begin
      outValid <= 1'b0;
      outBranchTaken <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage; directed vectors, expected results queued at issue and checked by a monitor
module tb_ex_stage;
  localparam int N = 32;
  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, SUB = 4'b0110,
                         SLT = 4'b0111, NOR_ = 4'b1100, MUL = 4'b1000, UNDEF = 4'b0011;
  logic clk, rst_n, inValid, inFlush, inAluSrc, inRegDst, inBranch;
  logic [31:0] inAdder, inRD1, inRD2, inSignExt;
  logic [4:0] inInsA, inInsB;
  logic [3:0] inAluOp;
  logic outStall, outValid, outZero, outBranchTaken;
  logic [31:0] outAluResult, outBranchTarget, outWriteData;
  logic [4:0] outWriteReg;
  logic outOverflow;
  typedef struct {
    logic [31:0] res, tgt, wd;
    logic [4:0] wr;
    logic z, tk, ov;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int retired = 0;
  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inFlush(inFlush), .inAdder(inAdder),
    .inRD1(inRD1), .inRD2(inRD2), .inSignExt(inSignExt), .inInsA(inInsA), .inInsB(inInsB),
    .inAluOp(inAluOp), .inAluSrc(inAluSrc), .inRegDst(inRegDst), .inBranch(inBranch),
    .outStall(outStall), .outValid(outValid), .outAluResult(outAluResult),
    .outBranchTarget(outBranchTarget), .outZero(outZero), .outBranchTaken(outBranchTaken),
    .outWriteData(outWriteData), .outWriteReg(outWriteReg)
`ifdef EX_OVERFLOW_EN
    , .outOverflow(outOverflow)
`endif
  );
`ifndef EX_OVERFLOW_EN
  assign outOverflow = 1'b0;
`endif
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  // monitor: every cycle the DUT presents outValid is one retired instruction
  initial forever begin
    @(posedge clk);
    if (rst_n && outValid) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_retire: got result %h with empty scoreboard", outAluResult);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("r%0d_result", retired), outAluResult, e.res);
        chk($sformatf("r%0d_target", retired), outBranchTarget, e.tgt);
        chk($sformatf("r%0d_wdata", retired), outWriteData, e.wd);
        chk($sformatf("r%0d_flags_wreg", retired), {24'd0, outZero, outBranchTaken, 1'b0, outWriteReg},
            {24'd0, e.z, e.tk, 1'b0, e.wr});
`ifdef EX_OVERFLOW_EN
        chk($sformatf("r%0d_overflow", retired), {31'd0, outOverflow}, {31'd0, e.ov});
`endif
        retired++;
      end
    end
  end
  task automatic issue(input logic [3:0] op, input logic [31:0] rd1, rd2, se, adder,
                       input logic src, dst, br, input logic [4:0] ia, ib,
                       input int estall, input logic scr, input logic [31:0] eres, input logic eov);
    exp_t e;
    int n;
    logic s;
    inAluOp = op; inRD1 = rd1; inRD2 = rd2; inSignExt = se; inAdder = adder;
    inAluSrc = src; inRegDst = dst; inBranch = br; inInsA = ia; inInsB = ib; inValid = 1'b1;
    e.res = eres; e.tgt = adder + (se << 2); e.wd = rd2; e.wr = dst ? ib : ia;
    e.z = eres == 32'd0; e.tk = br & e.z; e.ov = eov;
    q.push_back(e);
    n = 0;
    while (n <= 100) begin
      #1 s = outStall;
      @(negedge clk);
      #1;
      if (!s) break;
      n++;
      if (scr) begin
        inRD1 = 32'hDEAD0001; inRD2 = 32'hBEEF0002; inSignExt = 32'h7; inAdder = 32'h999;
        inInsA = 5'd30; inInsB = 5'd31; inBranch = ~br; inAluOp = ADD;
      end
    end
    chk($sformatf("stall_cycles_op%b", op), n, estall);
    inValid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; inValid = 1'b0; inFlush = 1'b0; inAluSrc = 1'b0; inRegDst = 1'b0; inBranch = 1'b0;
    inAdder = '0; inRD1 = '0; inRD2 = '0; inSignExt = '0; inInsA = '0; inInsB = '0; inAluOp = '0;
    #2;
    chk("reset_result", outAluResult, 0);
    chk("reset_valid_flags", {outValid, outZero, outBranchTaken, outOverflow, outWriteReg}, 0);
    chk("reset_target_wdata", outBranchTarget | outWriteData, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    issue(ADD, 5, 7, 0, 0, 0, 1, 0, 0, 3, 0, 0, 12, 0);
    issue(SUB, 9, 9, 4, 32'h100, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    issue(SLT, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0);
    issue(SLT, 0, 32'h55, 32'hFFFFFFFE, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0);
    issue(AND_, 32'hF0F0, 32'hFF00, 0, 32'h40, 0, 1, 0, 0, 5, 0, 0, 32'hF000, 0);
    issue(OR_, 32'hF0F0, 32'hFF00, 0, 0, 0, 1, 0, 0, 6, 0, 0, 32'hFFF0, 0);
    issue(NOR_, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0, 8, 0, 0, 0, 32'hFFFF000F, 0);
    issue(UNDEF, 32'h1234, 32'h5678, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0);
    issue(SUB, 9, 8, 1, 32'h20, 0, 0, 1, 11, 0, 0, 0, 1, 0);
    issue(MUL, 32'h12345, 32'h100, 0, 0, 0, 1, 0, 0, 9, N, 0, 32'h01234500, 0);
    issue(ADD, 32'h10, 32'h20, 0, 0, 0, 1, 0, 0, 12, 0, 0, 32'h30, 0);
    issue(MUL, 32'h10000, 32'h10000, 3, 32'h200, 0, 1, 1, 0, 7, N, 1, 0, 0);
    issue(MUL, 3, 32'h77, 32'hFFFFFFFF, 0, 1, 0, 0, 13, 0, N, 0, 32'hFFFFFFFD, 0);
    issue(ADD, 32'h7FFFFFFF, 1, 0, 0, 0, 1, 0, 0, 14, 0, 0, 32'h80000000, 1);
    issue(SUB, 5, 3, 0, 0, 0, 1, 0, 0, 15, 0, 0, 2, 0);
    issue(ADD, 32'h7FFFFFFF, 1, 0, 0, 0, 1, 0, 0, 14, 0, 0, 32'h80000000, 1);
    inAluOp = MUL; inRD1 = 32'h3; inRD2 = 32'h5; inAluSrc = 1'b0; inValid = 1'b1;
    repeat (11) begin
      @(negedge clk);
      #1;
    end
    chk("mul_cycle10_stall", {31'd0, outStall}, 1);
    inFlush = 1'b1;
    #1 chk("flush_gates_stall", {31'd0, outStall}, 0);
    @(negedge clk);
    #1 inFlush = 1'b0; inValid = 1'b0;
    #1 chk("flush_valid_taken_stall", {outValid, outBranchTaken, outStall}, 0);
    chk("flush_overflow", {31'd0, outOverflow}, 0);
    chk("flush_holds_result", outAluResult, 32'h80000000);
    issue(ADD, 32'h10, 32'h20, 0, 32'h8, 0, 1, 0, 0, 12, 0, 0, 32'h30, 0);
    inAluOp = MUL; inRD1 = 32'h3; inRD2 = 32'h5; inValid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
    end
    #2 inValid = 1'b0; rst_n = 1'b0;
    #1 chk("async_reset_result", outAluResult, 0);
    chk("async_reset_flags_wreg", {outValid, outZero, outBranchTaken, outStall, outWriteReg}, 0);
    chk("async_reset_target_wdata", outBranchTarget | outWriteData, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    issue(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 1, N, 0, 1, 0);
    issue(ADD, 2, 3, 0, 0, 0, 1, 0, 0, 2, 0, 0, 5, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
